audio_time_counter: RTL

//  Elapsed-time counter for the recorder/player; sits between Top's control FSM and the 7-seg decoders.

---
 rtl/audio_time_counter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/audio_time_counter.sv
// -----------------------------------------------------------------------------
// audio_time_counter
//
// Elapsed-time counter for the recorder/player. It sits between the top-level
// control FSM and the 7-segment decoders. It counts recorded-audio seconds
// during record or playback, using the audio clock as its only timebase.
// Playback time scales with the speed/fast switch settings. The output is
// registered binary seconds.
//
// The time base is a fractional accumulator rather than a plain prescaler.
// Each RUN cycle adds `inc` to `acc`. When `acc` reaches `lim`, one second is
// credited and only `lim` is subtracted, so any residue carries into the next
// second.
//   fast mode : inc = spd, lim = CLK_HZ        (spd seconds per real second)
//   slow mode : inc = 1,   lim = CLK_HZ * spd  (1 second per spd real seconds)
//
// State table
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | not counting; o_time holds the last value for display
//   ST_RUN   | accumulating elapsed time every cycle
//   ST_PAUSE | acc and o_time frozen; a start pulse resumes without clearing
//
// Ports
//   i_clk      in  1   audio clock, the only clock
//   i_rst      in  1   synchronous, active-high reset
//   i_start    in  1   pulse: start from IDLE (clears) or resume from PAUSE
//   i_pause    in  1   pulse: RUN -> PAUSE
//   i_stop     in  1   pulse: any state -> IDLE, time held for display
//   i_speed    in  4   speed factor; 2..8 used as-is, anything else acts as 1
//   i_fast     in  1   1: N seconds per real second, 0: 1 second per N real s
//   o_time     out TW  elapsed seconds, saturates at MAX_SEC
//   o_running  out 1   high while in RUN
//   o_paused   out 1   high while in PAUSE
//   o_done     out 1   one-cycle pulse when o_time reaches MAX_SEC
// -----------------------------------------------------------------------------
module audio_time_counter #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int MAX_SEC = 32,
  parameter int TW      = $clog2(MAX_SEC + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_pause,
  input  logic          i_stop,
  input  logic [3:0]    i_speed,
  input  logic          i_fast,
  output logic [TW-1:0] o_time,
  output logic          o_running,
  output logic          o_paused,
  output logic          o_done
);

  // The sum acc + inc must hold up to CLK_HZ*8 + 8.
  // With CLK_HZ = 12 MHz this needs 27 bits.
  localparam int AW = $clog2(CLK_HZ * 8 + 8 + 1);

  localparam logic [AW-1:0] CLK_LIM = AW'(CLK_HZ);
  localparam logic [TW-1:0] MAX_T   = TW'(MAX_SEC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_n;
  logic [TW-1:0] time_n;
  logic          done_n;

  logic [3:0]    spd;
  logic [AW-1:0] spd_w;
  logic [AW-1:0] inc;
  logic [AW-1:0] lim;
  logic [AW-1:0] acc_sum;
  logic [TW-1:0] time_inc;

  // Speed decode and accumulator step.
  // Speed and mode are sampled every cycle, so a switch change takes effect
  // on the next edge. acc is not cleared on such a change. If lim drops
  // below acc, the >= compare still credits one second per cycle and the
  // excess drains over the following cycles.
  always_comb begin
    spd = 4'd1;
    if ((i_speed >= 4'd2) && (i_speed <= 4'd8)) begin
      spd = i_speed;
    end
    spd_w    = {{(AW-4){1'b0}}, spd};
    inc      = i_fast ? spd_w : AW'(1);
    lim      = i_fast ? CLK_LIM : AW'(CLK_LIM * spd_w);
    acc_sum  = acc + inc;
    time_inc = o_time + TW'(1);
  end

  // Next-state logic. Command priority is stop > start > pause.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    time_n  = o_time;
    done_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_stop) begin
          state_n = ST_IDLE;
        end else if (i_start) begin
          state_n = ST_RUN;
          acc_n   = '0;
          time_n  = '0;
        end
      end

      ST_RUN: begin
        if (i_stop) begin
          state_n = ST_IDLE;
        end else if (i_pause) begin
          state_n = ST_PAUSE;
        end else begin
          // A start pulse while running is ignored, so counting continues.
          if (acc_sum >= lim) begin
            time_n = time_inc;
            if (time_inc == MAX_T) begin
              done_n  = 1'b1;
              state_n = ST_IDLE;
              acc_n   = '0;
            end else begin
              acc_n = acc_sum - lim;
            end
          end else begin
            acc_n = acc_sum;
          end
        end
      end

      ST_PAUSE: begin
        if (i_stop) begin
          state_n = ST_IDLE;
        end else if (i_start) begin
          state_n = ST_RUN;
        end
      end

      default: begin
        state_n = ST_IDLE;
        acc_n   = '0;
      end
    endcase
  end

  // Status flags are registered from the next state, so they line up with
  // the state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      o_time    <= '0;
      o_running <= 1'b0;
      o_paused  <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      o_time    <= time_n;
      o_running <= (state_n == ST_RUN);
      o_paused  <= (state_n == ST_PAUSE);
      o_done    <= done_n;
    end
  end

endmodule
